// File: rtl/lc3_pipe_controller_if.sv
// Signal bundle between the LC-3 pipeline controller (master) and the stages/memory port it steers (slave).
interface lc3_pipe_controller_if;
   logic        complete_data;
   logic        complete_instr;
   logic [15:0] IR;
   logic [15:0] IR_Exec;
   logic [2:0]  NZP;
   logic        enable_updatePC;
   logic        enable_fetch;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic        bypass_alu_1;
   logic        bypass_alu_2;

   modport master (
      input  complete_data, complete_instr, IR, IR_Exec, NZP,
      output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
      output br_taken, mem_state, bypass_alu_1, bypass_alu_2
   );

   modport slave (
      output complete_data, complete_instr, IR, IR_Exec, NZP,
      input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
      input  br_taken, mem_state, bypass_alu_1, bypass_alu_2
   );
endinterface

// File: rtl/lc3_pipe_controller.sv
// LC-3 five-stage pipeline controller: stage enables, memory-access FSM, control stall, operand bypass.
// Build option LC3_CTRL_BYPASS_EN: forward ALU results; when undefined, dependences insert one bubble.
module lc3_pipe_controller (
   input logic                   clock,
   input logic                   reset,
   lc3_pipe_controller_if.master pipe
);
   typedef enum logic [1:0] {
      MEM_READ  = 2'd0,
      MEM_IND   = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_IDLE  = 2'd3
   } mem_state_t;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   function automatic logic is_alu(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
   endfunction

   function automatic logic is_mem(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) ||
             (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
   endfunction

   mem_state_t state, state_nxt;
   logic       load_op, load_op_nxt;
   logic       mem_done, mem_done_nxt;
   logic       mem_busy;
   logic [2:0] ramp, ramp_nxt;
   logic [1:0] cs, cs_nxt;
   logic       en_pc_nxt, en_fetch_nxt, en_dec_nxt, en_exe_nxt, en_wb_nxt;
   logic [3:0] op_d, op_x;
   logic [2:0] dr_x;
   logic       dep_ok, dep_1, dep_2, hazard;
   logic       unused_bits;

   assign op_d = pipe.IR[15:12];
   assign op_x = pipe.IR_Exec[15:12];
   assign dr_x = pipe.IR_Exec[11:9];
   assign unused_bits = ^{pipe.IR[11:9], pipe.IR[4:3], pipe.IR_Exec[8:0]};

   assign dep_ok = pipe.enable_execute && is_alu(op_x) &&
                   (is_alu(op_d) || (op_d == OP_LDR) || (op_d == OP_STR));
   assign dep_1  = dep_ok && (pipe.IR[8:6] == dr_x);
   assign dep_2  = dep_ok && is_alu(op_d) && !pipe.IR[5] && (pipe.IR[2:0] == dr_x);

`ifdef LC3_CTRL_BYPASS_EN
   assign pipe.bypass_alu_1 = dep_1;
   assign pipe.bypass_alu_2 = dep_2;
   assign hazard            = 1'b0;
`else
   assign pipe.bypass_alu_1 = 1'b0;
   assign pipe.bypass_alu_2 = 1'b0;
   assign hazard            = dep_1 || dep_2;
`endif

   assign pipe.br_taken = pipe.enable_updatePC && (cs == 2'd1) &&
                          ((op_x == OP_JMP) || ((op_x == OP_BR) && |(dr_x & pipe.NZP)));
   assign pipe.mem_state = state;

   always_comb begin
      state_nxt   = state;
      load_op_nxt = load_op;
      case (state)
         MEM_IDLE: begin
            // complete_data is deliberately ignored while idle
            if (pipe.enable_execute && is_mem(op_x)) begin
               load_op_nxt = (op_x == OP_LD) || (op_x == OP_LDR) || (op_x == OP_LDI);
               if ((op_x == OP_LD) || (op_x == OP_LDR))      state_nxt = MEM_READ;
               else if ((op_x == OP_ST) || (op_x == OP_STR)) state_nxt = MEM_WRITE;
               else                                          state_nxt = MEM_IND;
            end
         end
         MEM_IND:  if (pipe.complete_data) state_nxt = load_op ? MEM_READ : MEM_WRITE;
         default:  if (pipe.complete_data) state_nxt = MEM_IDLE;
      endcase

      mem_busy     = (state != MEM_IDLE) || (state_nxt != MEM_IDLE);
      mem_done_nxt = (state != MEM_IDLE) && (state_nxt == MEM_IDLE);
      ramp_nxt     = (!mem_busy && (ramp != 3'd4)) ? ramp + 3'd1 : ramp;

      if (state != MEM_IDLE)                                     cs_nxt = cs;
      else if (cs != 2'd0)                                       cs_nxt = cs - 2'd1;
      else if (pipe.enable_decode && ((op_d == OP_BR) || (op_d == OP_JMP))) cs_nxt = 2'd3;
      else                                                       cs_nxt = 2'd0;

      en_pc_nxt    = (ramp_nxt >= 3'd1);
      en_fetch_nxt = (ramp_nxt >= 3'd1);
      en_dec_nxt   = (ramp_nxt >= 3'd2);
      en_exe_nxt   = (ramp_nxt >= 3'd3);
      en_wb_nxt    = (ramp_nxt >= 3'd4);

      if (!pipe.complete_instr) begin
         en_pc_nxt    = 1'b0;
         en_fetch_nxt = 1'b0;
         en_dec_nxt   = 1'b0;
      end
      if (cs_nxt[1]) begin
         en_pc_nxt    = 1'b0;
         en_fetch_nxt = 1'b0;
      end
      if (cs_nxt != 2'd0) en_dec_nxt = 1'b0;
      if (cs_nxt == 2'd1) en_pc_nxt  = 1'b1;
      if (hazard) begin
         en_pc_nxt    = 1'b0;
         en_fetch_nxt = 1'b0;
         en_dec_nxt   = 1'b0;
         en_exe_nxt   = 1'b0;
      end
      // first cycle after a memory sequence: writeback only for loads
      if (mem_done) en_wb_nxt = load_op;
      if (mem_busy) begin
         en_pc_nxt    = 1'b0;
         en_fetch_nxt = 1'b0;
         en_dec_nxt   = 1'b0;
         en_exe_nxt   = 1'b0;
         en_wb_nxt    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state                 <= MEM_IDLE;
         load_op               <= 1'b0;
         mem_done              <= 1'b0;
         ramp                  <= 3'd0;
         cs                    <= 2'd0;
         pipe.enable_updatePC  <= 1'b0;
         pipe.enable_fetch     <= 1'b0;
         pipe.enable_decode    <= 1'b0;
         pipe.enable_execute   <= 1'b0;
         pipe.enable_writeback <= 1'b0;
      end else begin
         state                 <= state_nxt;
         load_op               <= load_op_nxt;
         mem_done              <= mem_done_nxt;
         ramp                  <= ramp_nxt;
         cs                    <= cs_nxt;
         pipe.enable_updatePC  <= en_pc_nxt;
         pipe.enable_fetch     <= en_fetch_nxt;
         pipe.enable_decode    <= en_dec_nxt;
         pipe.enable_execute   <= en_exe_nxt;
         pipe.enable_writeback <= en_wb_nxt;
      end
   end
endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for lc3_pipe_controller; expectations follow LC3_CTRL_BYPASS_EN when set.
module tb_lc3_pipe_controller;
   logic clock;
   logic reset;
   int   tests;
   int   fails;

   lc3_pipe_controller_if bus ();

   lc3_pipe_controller dut (
      .clock (clock),
      .reset (reset),
      .pipe  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [15:0] FILL = 16'hE000;

   function automatic logic [7:0] en();
      return {3'b000, bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
              bus.enable_execute, bus.enable_writeback};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic ctrl_run(input string tag, input logic [15:0] ctl, input logic [2:0] nzp,
                           input logic exp_br);
      bus.IR = ctl; bus.IR_Exec = FILL; bus.NZP = nzp;
      step();
      check({tag, "_cs3_en"}, en(), 8'b00011);
      check({tag, "_cs3_br"}, {7'd0, bus.br_taken}, 8'd0);
      bus.IR = FILL; bus.IR_Exec = ctl;
      step();
      check({tag, "_cs2_en"}, en(), 8'b00011);
      check({tag, "_cs2_br"}, {7'd0, bus.br_taken}, 8'd0);
      step();
      check({tag, "_cs1_en"}, en(), 8'b11011);
      check({tag, "_cs1_br"}, {7'd0, bus.br_taken}, {7'd0, exp_br});
      step();
      check({tag, "_cs0_en"}, en(), 8'b11111);
      check({tag, "_cs0_br"}, {7'd0, bus.br_taken}, 8'd0);
      bus.IR_Exec = FILL; bus.NZP = 3'b000;
   endtask

   task automatic byp_case(input string tag, input logic [15:0] ir, input logic b1, input logic b2);
      bus.IR_Exec = 16'h1240; bus.IR = ir;
      #1;
`ifdef LC3_CTRL_BYPASS_EN
      check({tag, "_byp"}, {6'd0, bus.bypass_alu_1, bus.bypass_alu_2}, {6'd0, b1, b2});
      step();
      check({tag, "_en"}, en(), 8'b11111);
`else
      check({tag, "_byp"}, {6'd0, bus.bypass_alu_1, bus.bypass_alu_2}, 8'd0);
      step();
      check({tag, "_en"}, en(), (b1 || b2) ? 8'b00001 : 8'b11111);
`endif
      bus.IR = FILL; bus.IR_Exec = FILL;
      step();
      check({tag, "_after"}, en(), 8'b11111);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      bus.complete_data  = 1'b0;
      bus.complete_instr = 1'b1;
      bus.IR      = FILL;
      bus.IR_Exec = FILL;
      bus.NZP     = 3'b000;

      step();
      check("rst_en", en(), 8'b00000);
      check("rst_ms", {6'd0, bus.mem_state}, 8'd3);
      check("rst_br", {7'd0, bus.br_taken}, 8'd0);
      check("rst_byp", {6'd0, bus.bypass_alu_1, bus.bypass_alu_2}, 8'd0);

      reset = 1'b1;
      step(); check("ramp1", en(), 8'b11000); check("ramp1_ms", {6'd0, bus.mem_state}, 8'd3);
      step(); check("ramp2", en(), 8'b11100); check("ramp2_ms", {6'd0, bus.mem_state}, 8'd3);
      step(); check("ramp3", en(), 8'b11110); check("ramp3_ms", {6'd0, bus.mem_state}, 8'd3);
      step(); check("ramp4", en(), 8'b11111); check("ramp4_ms", {6'd0, bus.mem_state}, 8'd3);

      // LDI with data always ready
      bus.IR_Exec = 16'hA403; bus.complete_data = 1'b1;
      step(); check("ldi_ms1", {6'd0, bus.mem_state}, 8'd1); check("ldi_en1", en(), 8'd0);
      bus.IR_Exec = FILL;
      step(); check("ldi_ms0", {6'd0, bus.mem_state}, 8'd0); check("ldi_en0", en(), 8'd0);
      step(); check("ldi_ms3", {6'd0, bus.mem_state}, 8'd3); check("ldi_en3", en(), 8'd0);
      step(); check("ldi_wb", en(), 8'b11111);
      bus.complete_data = 1'b0;

      // STI with data delayed in the indirect state
      bus.IR_Exec = 16'hB000;
      step(); check("sti_ms1a", {6'd0, bus.mem_state}, 8'd1);
      bus.IR_Exec = FILL;
      step(); check("sti_ms1b", {6'd0, bus.mem_state}, 8'd1);
      step(); check("sti_ms1c", {6'd0, bus.mem_state}, 8'd1);
      step(); check("sti_ms1d", {6'd0, bus.mem_state}, 8'd1); check("sti_en1d", en(), 8'd0);
      bus.complete_data = 1'b1;
      step(); check("sti_ms2", {6'd0, bus.mem_state}, 8'd2); check("sti_en2", en(), 8'd0);
      step(); check("sti_ms3", {6'd0, bus.mem_state}, 8'd3); check("sti_en3", en(), 8'd0);
      step(); check("sti_nowb", en(), 8'b11110);
      step(); check("sti_resume", en(), 8'b11111);
      bus.complete_data = 1'b0;

      // LD minimum stall
      bus.IR_Exec = 16'h2000; bus.complete_data = 1'b1;
      step(); check("ld_ms0", {6'd0, bus.mem_state}, 8'd0); check("ld_en0", en(), 8'd0);
      bus.IR_Exec = FILL;
      step(); check("ld_ms3", {6'd0, bus.mem_state}, 8'd3); check("ld_en3", en(), 8'd0);
      step(); check("ld_wb", en(), 8'b11111);
      bus.complete_data = 1'b0;

      // fetch stall
      bus.complete_instr = 1'b0;
      step(); check("fstall_en", en(), 8'b00011);
      bus.complete_instr = 1'b1;
      step(); check("fstall_rel", en(), 8'b11111);

      ctrl_run("brz_t", 16'h0402, 3'b010, 1'b1);
      ctrl_run("brz_nt", 16'h0402, 3'b100, 1'b0);
      ctrl_run("jmp", 16'hC000, 3'b000, 1'b1);

      byp_case("add_dep2", 16'h1441, 1'b1, 1'b1);
      byp_case("str_dep", 16'h7040, 1'b1, 1'b0);
      byp_case("and_src2", 16'h5001, 1'b0, 1'b1);
      byp_case("imm_nodep", 16'h1020, 1'b0, 1'b0);

      // reset during a store
      bus.IR_Exec = 16'h3000; bus.complete_data = 1'b0;
      step(); check("st_ms2", {6'd0, bus.mem_state}, 8'd2);
      bus.IR_Exec = FILL; reset = 1'b0;
      step();
      check("mrst_en", en(), 8'd0);
      check("mrst_ms", {6'd0, bus.mem_state}, 8'd3);
      check("mrst_br", {7'd0, bus.br_taken}, 8'd0);
      check("mrst_byp", {6'd0, bus.bypass_alu_1, bus.bypass_alu_2}, 8'd0);
      reset = 1'b1;
      step(); check("mrst_ramp1", en(), 8'b11000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1, "watchdog");
   end
endmodule
